// File: rtl/conv_1x1_sched_pkg.sv
// Shared types and default dimensions for the 1x1 convolution sequencer.
package conv_1x1_sched_pkg;

  typedef enum logic [2:0] {IDLE, LOAD_W, LATCH, RUN, DRAIN, DONE} state_t;

  localparam int DEF_IMAGE_WIDTH     = 16;
  localparam int DEF_IMAGE_HEIGHT    = 16;
  localparam int DEF_CHANNEL_NUM_IN  = 256;
  localparam int DEF_CHANNEL_NUM_OUT = 512;
  localparam int DEF_OUTSTD_WIDTH    = 6;
  localparam int IMAGE_SIZE          = DEF_IMAGE_WIDTH * DEF_IMAGE_HEIGHT;

  // $clog2(1) is 0; every counter and bus must stay at least one bit wide.
  function automatic int width_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/conv_1x1_addr_gen.sv
// pix/cin/cout counters with plane wrap and pixel/weight address generation.
// Optional stride-2 pixel skipping is built in with CONV1X1_SCHED_STRIDE2_EN.
module conv_1x1_addr_gen
  import conv_1x1_sched_pkg::*;
#(
  parameter int IMAGE_WIDTH     = DEF_IMAGE_WIDTH,
  parameter int IMAGE_HEIGHT    = DEF_IMAGE_HEIGHT,
  parameter int CHANNEL_NUM_IN  = DEF_CHANNEL_NUM_IN,
  parameter int CHANNEL_NUM_OUT = DEF_CHANNEL_NUM_OUT,
  localparam int IMG_SIZE = IMAGE_WIDTH * IMAGE_HEIGHT,
  localparam int WA_W     = width_of(CHANNEL_NUM_IN * CHANNEL_NUM_OUT),
  localparam int PA_W     = width_of(IMG_SIZE * CHANNEL_NUM_IN),
  localparam int CO_W     = width_of(CHANNEL_NUM_OUT)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clr,
  input  logic            issue,
`ifdef CONV1X1_SCHED_STRIDE2_EN
  input  logic            stride2,
`endif
  output logic [PA_W-1:0] pxl_addr,
  output logic [WA_W-1:0] w_addr,
  output logic [CO_W-1:0] cout_idx,
  output logic            cin_first,
  output logic            cin_last,
  output logic            plane_end,
  output logic            job_end
);

  localparam int PIX_W = width_of(IMG_SIZE);
  localparam int CI_W  = width_of(CHANNEL_NUM_IN);

  logic [PIX_W-1:0] pix;
  logic [PIX_W-1:0] pix_step;
  logic [CI_W-1:0]  cin;
  logic [CO_W-1:0]  cout;
  logic             pix_last;
  logic             cout_last;

`ifdef CONV1X1_SCHED_STRIDE2_EN
  localparam int COL_W   = width_of(IMAGE_WIDTH / 2);
  localparam int S2_LAST = (IMAGE_HEIGHT - 2) * IMAGE_WIDTH + IMAGE_WIDTH - 2;

  logic [COL_W-1:0] col;
  logic             col_last;
  logic             stride_q;

  // pix is the linear offset in the plane; stride-2 hops two columns, or
  // past the odd row at the end of an even row.
  assign col_last = (col == COL_W'(IMAGE_WIDTH / 2 - 1));
  assign pix_last = stride_q ? (pix == PIX_W'(S2_LAST)) : (pix == PIX_W'(IMG_SIZE - 1));

  always_comb begin
    pix_step = PIX_W'(1);
    if (stride_q)
      pix_step = col_last ? PIX_W'(IMAGE_WIDTH + 2) : PIX_W'(2);
  end
`else
  assign pix_last = (pix == PIX_W'(IMG_SIZE - 1));
  assign pix_step = PIX_W'(1);
`endif

  assign cin_first = (cin == '0);
  assign cin_last  = (cin == CI_W'(CHANNEL_NUM_IN - 1));
  assign cout_last = (cout == CO_W'(CHANNEL_NUM_OUT - 1));
  assign plane_end = issue & pix_last;
  assign job_end   = cin_last & cout_last;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pix  <= '0;
      cin  <= '0;
      cout <= '0;
`ifdef CONV1X1_SCHED_STRIDE2_EN
      col      <= '0;
      stride_q <= 1'b0;
`endif
    end else if (clr) begin
      pix  <= '0;
      cin  <= '0;
      cout <= '0;
`ifdef CONV1X1_SCHED_STRIDE2_EN
      col      <= '0;
      stride_q <= stride2;
`endif
    end else if (issue) begin
      if (pix_last) begin
        pix <= '0;
`ifdef CONV1X1_SCHED_STRIDE2_EN
        col <= '0;
`endif
        if (cin_last) begin
          cin  <= '0;
          cout <= cout_last ? '0 : cout + 1'b1;
        end else begin
          cin <= cin + 1'b1;
        end
      end else begin
        pix <= pix + pix_step;
`ifdef CONV1X1_SCHED_STRIDE2_EN
        col <= col_last ? '0 : col + 1'b1;
`endif
      end
    end
  end

  assign pxl_addr = PA_W'(cin) * PA_W'(IMG_SIZE) + PA_W'(pix);
  assign w_addr   = WA_W'(cout) * WA_W'(CHANNEL_NUM_IN) + WA_W'(cin);
  assign cout_idx = cout;

endmodule

// File: rtl/conv_1x1_sched.sv
// 1x1 convolution sequencer: weight fetch, plane streaming, drain and done.
// Define CONV1X1_SCHED_STRIDE2_EN to add the stride2 input.
module conv_1x1_sched
  import conv_1x1_sched_pkg::*;
#(
  parameter int IMAGE_WIDTH     = DEF_IMAGE_WIDTH,
  parameter int IMAGE_HEIGHT    = DEF_IMAGE_HEIGHT,
  parameter int CHANNEL_NUM_IN  = DEF_CHANNEL_NUM_IN,
  parameter int CHANNEL_NUM_OUT = DEF_CHANNEL_NUM_OUT,
  parameter int OUTSTD_WIDTH    = DEF_OUTSTD_WIDTH,
  localparam int WA_W = width_of(CHANNEL_NUM_IN * CHANNEL_NUM_OUT),
  localparam int PA_W = width_of(IMAGE_WIDTH * IMAGE_HEIGHT * CHANNEL_NUM_IN),
  localparam int CO_W = width_of(CHANNEL_NUM_OUT)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
`ifdef CONV1X1_SCHED_STRIDE2_EN
  input  logic            stride2,
`endif
  output logic            busy,
  output logic            done,
  output logic            w_rd_en,
  output logic [WA_W-1:0] w_addr,
  input  logic            w_valid,
  output logic            load_weights,
  output logic            pxl_rd_en,
  output logic [PA_W-1:0] pxl_addr,
  input  logic            pxl_rdy,
  output logic            acc_first,
  output logic            acc_last,
  output logic [CO_W-1:0] cout_idx,
  input  logic            mul_valid
);

  // state  | meaning
  // IDLE   | waiting for start
  // LOAD_W | weight fetch requested, waiting for w_valid
  // LATCH  | load_weights pulse
  // RUN    | one pixel per cycle while pxl_rdy
  // DRAIN  | all pixels issued, waiting for in-flight products
  // DONE   | done pulse

  state_t                  state;
  logic [OUTSTD_WIDTH-1:0] outstanding;
  logic                    start_acc;
  logic                    retire;
  logic                    drain_empty;
  logic                    cin_first;
  logic                    cin_last;
  logic                    plane_end;
  logic                    job_end;

  assign start_acc = (state == IDLE) & start;
  assign pxl_rd_en = (state == RUN) & pxl_rdy;
  assign acc_first = pxl_rd_en & cin_first;
  assign acc_last  = pxl_rd_en & cin_last;

  conv_1x1_addr_gen #(
    .IMAGE_WIDTH     (IMAGE_WIDTH),
    .IMAGE_HEIGHT    (IMAGE_HEIGHT),
    .CHANNEL_NUM_IN  (CHANNEL_NUM_IN),
    .CHANNEL_NUM_OUT (CHANNEL_NUM_OUT)
  ) u_addr_gen (
    .clk       (clk),
    .reset     (reset),
    .clr       (start_acc),
    .issue     (pxl_rd_en),
`ifdef CONV1X1_SCHED_STRIDE2_EN
    .stride2   (stride2),
`endif
    .pxl_addr  (pxl_addr),
    .w_addr    (w_addr),
    .cout_idx  (cout_idx),
    .cin_first (cin_first),
    .cin_last  (cin_last),
    .plane_end (plane_end),
    .job_end   (job_end)
  );

  // A retire with nothing in flight is a stray pulse and is dropped.
  assign retire = mul_valid & (outstanding != '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      outstanding <= '0;
    else if (pxl_rd_en && !retire)
      outstanding <= outstanding + 1'b1;
    else if (!pxl_rd_en && retire)
      outstanding <= outstanding - 1'b1;
  end

  // No issues happen in DRAIN, so the last retire can be taken on its own cycle.
  assign drain_empty = (outstanding == '0) ||
                       ((outstanding == OUTSTD_WIDTH'(1)) && retire);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      w_rd_en      <= 1'b0;
      load_weights <= 1'b0;
    end else begin
      done         <= 1'b0;
      load_weights <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state   <= LOAD_W;
            busy    <= 1'b1;
            w_rd_en <= 1'b1;
          end
        end
        LOAD_W: begin
          if (w_valid) begin
            state        <= LATCH;
            w_rd_en      <= 1'b0;
            load_weights <= 1'b1;
          end
        end
        LATCH: state <= RUN;
        RUN: begin
          if (plane_end) begin
            if (job_end) begin
              state <= DRAIN;
            end else begin
              state   <= LOAD_W;
              w_rd_en <= 1'b1;
            end
          end
        end
        DRAIN: begin
          if (drain_empty) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/conv_1x1_sched.md
Name: conv_1x1_sched

Overview:
- Sequencer for the 1x1 convolution datapath (pixel buffer, weight buffer, FP multiplier).
- For every (output channel, input channel) pair it:
  - fetches one weight and pulses load_weights;
  - streams the full input-channel plane through the multiplier;
  - tags the product stream with first/last flags for the downstream channel accumulator.
- Sits between the layer-level start/done handshake and the pixel/weight memories.

Parameters:
- IMAGE_WIDTH, 16, plane width in pixels
- IMAGE_HEIGHT, 16, plane height in pixels
- CHANNEL_NUM_IN, 256, input channels accumulated per output pixel
- CHANNEL_NUM_OUT, 512, output channels produced
- OUTSTD_WIDTH, 6, width of in-flight product counter (must cover multiplier latency + 1)

Ports:
- clk  in  1  clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle job request, sampled only in IDLE
- busy  out  1  high from cycle after accepted start until done pulse
- done  out  1  one-cycle pulse, job complete and pipeline drained
- w_rd_en  out  1  weight fetch request, held until w_valid
- w_addr  out  log2(CHANNEL_NUM_IN*CHANNEL_NUM_OUT)  = cout*CHANNEL_NUM_IN + cin
- w_valid  in  1  weight word present on weight bus this cycle
- load_weights  out  1  one-cycle pulse the cycle after w_valid; latches weight into weight buffer
- pxl_rd_en  out  1  pixel issue to pixel buffer; one pixel per cycle when high
- pxl_addr  out  log2(IMAGE_WIDTH*IMAGE_HEIGHT*CHANNEL_NUM_IN)  = cin*IMAGE_SIZE + pix
- pxl_rdy  in  1  pixel source can accept an issue this cycle
- acc_first  out  1  qualifies the issued pixel: cin==0 (accumulator overwrites)
- acc_last  out  1  qualifies the issued pixel: cin==CHANNEL_NUM_IN-1 (accumulator emits result)
- cout_idx  out  log2(CHANNEL_NUM_OUT)  current output channel
- mul_valid  in  1  multiplier result valid; retires one in-flight product

Behaviour:
- Reset: all outputs 0, FSM=IDLE, all counters 0, outstanding=0.
- IMAGE_SIZE = IMAGE_WIDTH*IMAGE_HEIGHT.
- FSM states:
  - IDLE: start=1 -> LOAD_W; clears cin, cout, pix.
  - LOAD_W: w_rd_en=1 with w_addr. On w_valid=1 -> LATCH.
  - LATCH: load_weights=1 for exactly one cycle -> RUN.
  - RUN: pxl_rd_en = pxl_rdy. Each issue increments pix. On the issue with pix==IMAGE_SIZE-1: pix wraps to 0 and the state advances.
    - If cin < CHANNEL_NUM_IN-1: cin++ -> LOAD_W.
    - Else: cin=0, cout++ -> LOAD_W.
    - If also cout == CHANNEL_NUM_OUT-1: -> DRAIN.
  - DRAIN: wait until outstanding==0 -> DONE.
  - DONE: done=1 for one cycle -> IDLE.
- Flow control: pxl_rd_en, acc_first and acc_last are combinational from state/pxl_rdy/cin. No issue when pxl_rdy=0 and counters hold.
- Outstanding counter:
  - +1 on each pxl_rd_en, -1 on mul_valid; both in the same cycle -> unchanged.
  - Overflow is a protocol error; never wraps in legal use.
  - mul_valid with outstanding==0 is ignored (saturate at 0).
- Weight handover: LOAD_W is entered only after the last pixel of the previous plane is issued, so weight/pixel pairing stays ordered. The multiplier pipeline is not drained between planes.
- start while busy: ignored.
- Reset asserted mid-job: immediate return to IDLE, all outputs 0, no done pulse.

Optional Feature:
- Macro CONV1X1_SCHED_STRIDE2_EN. When defined:
  - adds input port stride2 (1 bit), sampled at start and held for the job.
  - When stride2 was sampled as 1:
    - RUN issues only pixels with even row and even column;
    - plane length becomes (IMAGE_WIDTH/2)*(IMAGE_HEIGHT/2);
    - pxl_addr skips odd rows and columns.
  - When stride2 was sampled as 0: behaviour as baseline.
- When not defined: no stride2 port; stride-1 only.

Decomposition:
- Shared package conv_1x1_sched_pkg:
  - FSM state enum (IDLE, LOAD_W, LATCH, RUN, DRAIN, DONE);
  - derived widths via $clog2;
  - IMAGE_SIZE localparam.
- One natural sub-module: conv_1x1_addr_gen, holding the pix/cin/cout counters, wrap logic and pxl_addr/w_addr generation (including the stride-2 skip).
- The top keeps the FSM and the outstanding counter.

Test Plan:
- 2x2 image, CIN=2, COUT=2, pxl_rdy=1, w_valid one cycle after w_rd_en, 3-cycle multiplier model:
  - 4 weight fetches at w_addr 0,1,2,3;
  - 16 pixel issues;
  - acc_first on issues 1-4 and 9-12;
  - acc_last on issues 5-8 and 13-16;
  - done exactly 3 cycles after the last issue.
- Same config with pxl_rdy toggling 1,0,1,0: 16 issues total, pix never skips, pxl_addr sequence 0..7 per cout.
- w_valid delayed 5 cycles: w_rd_en held steady, load_weights a single pulse, no pxl_rd_en until after LATCH.
- Reset deasserted-then-asserted during RUN at pix=2: all outputs 0 next edge, busy=0, no done; a new start re-runs from w_addr 0.
- start pulsed during RUN: ignored, transaction counts unchanged.
- With CONV1X1_SCHED_STRIDE2_EN, 4x4 image, stride2=1, CIN=1, COUT=1: pixel addresses 0,2,8,10, then done.
